// File: rtl/btc_cc_block_seq.sv
`default_nettype none
// ============================================================================
//  Module   : btc_cc_block_seq
//  Purpose  : Sequences the colour-cell encode datapath to compress one 4x4
//             RGB555 block into a 64-bit cell. It buffers four pixel rows,
//             issues four RGB5MINMAX ops, reduces the endpoints by luma, then
//             issues four ENCCC1 ops back-to-back and presents the cell.
//  Revision : 1.0  initial release
// ============================================================================
module btc_cc_block_seq #(
    parameter logic [8:0]  UIXT_MINMAX = 9'h0,
    parameter logic [8:0]  UIXT_ENCCC1 = 9'h0,
    parameter int unsigned CC_LAT      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exHold,
    input  logic        inValid,
    output logic        inReady,
    input  logic [63:0] inRow,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] outCell,
    output logic [63:0] ccRs,
    output logic [31:0] ccRt,
    output logic [31:0] ccRp,
    output logic [8:0]  ccUIxt,
    input  logic [31:0] ccOut,
    output logic        busy
);

    localparam logic [1:0] c_LAST = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MMISS = 3'd2,
        S_MMDRN = 3'd3,
        S_ENISS = 3'd4,
        S_ENDRN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [63:0]         r_rows [4];
    logic [1:0]          r_rowCnt;
    logic [1:0]          r_opCnt;
    logic [1:0]          r_resCnt;
    logic [CC_LAT-1:0]   r_vld;
    logic [15:0]         r_min;
    logic [15:0]         r_max;
    logic [31:0]         r_idx;

    logic                w_inFire;
    logic                w_outFire;
    logic                w_issue;
    logic                w_capture;
    logic                w_mmPhase;
    logic                w_enPhase;
    logic                w_lastRes;
    logic                w_flat;
    logic [15:0]         w_resMin;
    logic [15:0]         w_resMax;

    // Luma ordering key built from the most significant colour bits.
    function automatic logic [7:0] lumaKey(input logic [15:0] p);
        return {p[9], p[8], p[14], p[4], p[7], p[13], p[3], p[6]};
    endfunction

    assign w_inFire  = inValid & inReady & ~exHold;
    assign w_outFire = outValid & outReady & ~exHold;
    assign w_issue   = ((r_state == S_MMISS) || (r_state == S_ENISS)) & ~exHold;
    // The oldest stage of the valid shift reg marks a result present on ccOut.
    assign w_capture = r_vld[CC_LAT-1] & ~exHold;
    assign w_mmPhase = (r_state == S_MMISS) || (r_state == S_MMDRN);
    assign w_enPhase = (r_state == S_ENISS) || (r_state == S_ENDRN);
    assign w_lastRes = w_capture & (r_resCnt == c_LAST);
    // Endpoints are settled for the whole encode phase, so this equals the
    // compare taken on entry to ENISS.
    assign w_flat    = (r_min == r_max);
    assign w_resMin  = ccOut[31:16];
    assign w_resMax  = ccOut[15:0];
    assign outCell   = {r_idx, r_min, r_max};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (!exHold) begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode and datapath drive; non-issuing states drive zeros.
    always_comb begin
        w_stateNext = r_state;
        inReady     = 1'b0;
        outValid    = 1'b0;
        busy        = 1'b1;
        ccRs        = 64'h0;
        ccRt        = 32'h0;
        ccRp        = 32'h0;
        ccUIxt      = 9'h0;
        case (r_state)
            S_IDLE: begin
                busy    = 1'b0;
                inReady = 1'b1;
                if (w_inFire) w_stateNext = S_LOAD;
            end
            S_LOAD: begin
                inReady = 1'b1;
                if (w_inFire && (r_rowCnt == c_LAST)) w_stateNext = S_MMISS;
            end
            S_MMISS: begin
                ccRs   = r_rows[r_opCnt];
                ccUIxt = UIXT_MINMAX;
                if (w_issue && (r_opCnt == c_LAST)) w_stateNext = S_MMDRN;
            end
            S_MMDRN: begin
                if (w_lastRes) w_stateNext = S_ENISS;
            end
            S_ENISS: begin
                ccRs   = r_rows[r_opCnt];
                ccRt   = {r_min, r_max};
                ccUIxt = UIXT_ENCCC1;
                if (w_issue && (r_opCnt == c_LAST)) w_stateNext = S_ENDRN;
            end
            S_ENDRN: begin
                if (w_lastRes) w_stateNext = S_DONE;
            end
            S_DONE: begin
                outValid = 1'b1;
                if (w_outFire) w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Row buffer and the row/op/result counters; all wrap to 0 after four.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_rows[i] <= 64'h0;
            r_rowCnt <= 2'd0;
            r_opCnt  <= 2'd0;
            r_resCnt <= 2'd0;
        end else if (!exHold) begin
            if (w_inFire) begin
                r_rows[r_rowCnt] <= inRow;
                r_rowCnt         <= r_rowCnt + 2'd1;
            end
            if (w_issue)   r_opCnt  <= r_opCnt + 2'd1;
            if (w_capture) r_resCnt <= r_resCnt + 2'd1;
        end
    end

    // Issue tracking: one bit per op in flight, aligned to the encoder latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
        end else if (!exHold) begin
            r_vld[0] <= w_issue;
            for (int i = 1; i < CC_LAT; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // Endpoint reduction; strict compares keep the earlier pixel on a tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_min <= 16'h0;
            r_max <= 16'h0;
        end else if (!exHold && w_capture && w_mmPhase) begin
            if (r_resCnt == 2'd0) begin
                r_min <= w_resMin;
                r_max <= w_resMax;
            end else begin
                if (lumaKey(w_resMin) < lumaKey(r_min)) r_min <= w_resMin;
                if (lumaKey(w_resMax) > lumaKey(r_max)) r_max <= w_resMax;
            end
        end
    end

    // Index bytes: cleared when a new block starts, filled row by row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx <= 32'h0;
        end else if (!exHold) begin
            if (w_inFire && (r_state == S_IDLE)) begin
                r_idx <= 32'h0;
            end else if (w_capture && w_enPhase) begin
                r_idx[{r_resCnt, 3'b000} +: 8] <= w_flat ? 8'h00 : ccOut[7:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btc_cc_block_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btc_cc_block_seq
//  Purpose  : Directed self-checking bench for btc_cc_block_seq, with a small
//             two-stage behavioural encoder standing in for the MUL3 lane.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btc_cc_block_seq;

    localparam logic [8:0] c_MMC = 9'h1A3;
    localparam logic [8:0] c_ENC = 9'h0C5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exHold = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [63:0] inRow = 64'h0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [63:0] outCell;
    logic [63:0] ccRs;
    logic [31:0] ccRt;
    logic [31:0] ccRp;
    logic [8:0]  ccUIxt;
    logic [31:0] ccOut;
    logic        busy;

    int nChecks = 0;
    int nFails  = 0;
    int lat;

    btc_cc_block_seq #(
        .UIXT_MINMAX (c_MMC),
        .UIXT_ENCCC1 (c_ENC),
        .CC_LAT      (2)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .exHold   (exHold),
        .inValid  (inValid),
        .inReady  (inReady),
        .inRow    (inRow),
        .outValid (outValid),
        .outReady (outReady),
        .outCell  (outCell),
        .ccRs     (ccRs),
        .ccRt     (ccRt),
        .ccRp     (ccRp),
        .ccUIxt   (ccUIxt),
        .ccOut    (ccOut),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] lumaY(input logic [15:0] p);
        return {p[9], p[8], p[14], p[4], p[7], p[13], p[3], p[6]};
    endfunction

    // Stand-in encoder: MINMAX returns {min,max} of a row, ENCCC1 returns
    // 2-bit indices per pixel relative to the endpoints on ccRt.
    function automatic logic [31:0] encModel(input logic [63:0] rs,
                                             input logic [31:0] rt,
                                             input logic [8:0]  ux);
        logic [15:0] mn, mx, px;
        logic [7:0]  y, ymn, ymx, idx;
        logic [8:0]  mid;
        if (ux == c_MMC) begin
            mn = rs[15:0];
            mx = rs[15:0];
            for (int i = 1; i < 4; i++) begin
                px = rs[16*i +: 16];
                if (lumaY(px) < lumaY(mn)) mn = px;
                if (lumaY(px) > lumaY(mx)) mx = px;
            end
            return {mn, mx};
        end else if (ux == c_ENC) begin
            ymn = lumaY(rt[31:16]);
            ymx = lumaY(rt[15:0]);
            mid = ({1'b0, ymn} + {1'b0, ymx}) >> 1;
            idx = 8'h0;
            for (int i = 0; i < 4; i++) begin
                y = lumaY(rs[16*i +: 16]);
                if (y == ymx)              idx[2*i +: 2] = 2'd3;
                else if (y == ymn)         idx[2*i +: 2] = 2'd0;
                else if ({1'b0, y} > mid)  idx[2*i +: 2] = 2'd2;
                else                       idx[2*i +: 2] = 2'd1;
            end
            return {24'h0, idx};
        end
        return 32'h0;
    endfunction

    logic [31:0] encS1 = 32'h0;
    logic [31:0] encS2 = 32'h0;
    assign ccOut = encS2;

    // Encoder pipeline, frozen by exHold like the real datapath.
    always @(posedge clock) begin
        if (!exHold) begin
            encS1 <= encModel(ccRs, ccRt, ccUIxt);
            encS2 <= encS1;
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendRow(input logic [63:0] row);
        int w;
        w = 0;
        inRow   = row;
        inValid = 1'b1;
        while (!inReady && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        if (w >= 50) checkVal("inReadyTimeout", 64'(inReady), 64'h1);
        @(posedge clock); #1;
        inValid = 1'b0;
    endtask

    task automatic loadRows(input logic [63:0] r0, input logic [63:0] r1,
                            input logic [63:0] r2, input logic [63:0] r3);
        sendRow(r0);
        sendRow(r1);
        sendRow(r2);
        sendRow(r3);
    endtask

    // Starts in the first cycle after the row3 accept edge; returns the cycle
    // number (1-based) in which outValid is first seen. Holds are 3 cycles.
    task automatic waitDone(input int h1, input int h2, output int latOut);
        int cnt;
        cnt = 0;
        exHold = (h1 > 0 && cnt >= h1 && cnt < h1 + 3) || (h2 > 0 && cnt >= h2 && cnt < h2 + 3);
        while (!outValid && cnt < 100) begin
            @(posedge clock); #1;
            cnt++;
            exHold = (h1 > 0 && cnt >= h1 && cnt < h1 + 3) || (h2 > 0 && cnt >= h2 && cnt < h2 + 3);
        end
        exHold = 1'b0;
        latOut = cnt + 1;
    endtask

    task automatic finishBlock(input string tag, input logic [63:0] expCell);
        checkVal({tag, "_outValid"}, 64'(outValid), 64'h1);
        checkVal({tag, "_outCell"}, outCell, expCell);
        outReady = 1'b1;
        @(posedge clock); #1;
        outReady = 1'b0;
        checkVal({tag, "_outValidDrop"}, 64'(outValid), 64'h0);
        checkVal({tag, "_idle"}, 64'(busy), 64'h0);
    endtask

    localparam logic [63:0] c_ROW_W   = {4{16'h7FFF}};
    localparam logic [63:0] c_ROW_K   = {4{16'h0000}};
    localparam logic [63:0] c_ROW_F   = {4{16'h1234}};
    localparam logic [63:0] c_T3_R0   = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
    localparam logic [63:0] c_T3_R1   = {4{16'h0210}};
    localparam logic [63:0] c_T3_R2   = {16'h0001, 16'h0001, 16'h0001, 16'h7FFE};
    localparam logic [63:0] c_EXP_T1  = 64'h0000FFFF_00007FFF;
    localparam logic [63:0] c_EXP_T2  = 64'h00000000_12341234;
    localparam logic [63:0] c_EXP_T3  = 64'hAA03AA03_00007FFF;

    initial begin
        #12;
        checkVal("rst_inReady", 64'(inReady), 64'h1);
        checkVal("rst_outValid", 64'(outValid), 64'h0);
        checkVal("rst_busy", 64'(busy), 64'h0);
        checkVal("rst_outCell", outCell, 64'h0);
        checkVal("rst_ccUIxt", 64'(ccUIxt), 64'h0);
        checkVal("rst_ccRsRtRp", {ccRs ^ {ccRt, ccRp}}, 64'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Bright rows over dark rows.
        loadRows(c_ROW_W, c_ROW_W, c_ROW_K, c_ROW_K);
        checkVal("t1_inReadyMM", 64'(inReady), 64'h0);
        checkVal("t1_uixtMM", 64'(ccUIxt), 64'(c_MMC));
        checkVal("t1_rsRow0", ccRs, c_ROW_W);
        waitDone(0, 0, lat);
        checkVal("t1_latency", 64'(lat), 64'd13);
        finishBlock("t1", c_EXP_T1);

        // Flat block: indices forced to zero.
        loadRows(c_ROW_F, c_ROW_F, c_ROW_F, c_ROW_F);
        waitDone(0, 0, lat);
        checkVal("t2_latency", 64'(lat), 64'd13);
        finishBlock("t2", c_EXP_T2);

        // Equal-luma endpoints in row0 and row2: row0 pixels win.
        loadRows(c_T3_R0, c_T3_R1, c_T3_R2, c_T3_R1);
        waitDone(0, 0, lat);
        checkVal("t3_latency", 64'(lat), 64'd13);
        checkVal("t3_min", 64'(outCell[31:16]), 64'h0000);
        checkVal("t3_max", 64'(outCell[15:0]), 64'h7FFF);
        finishBlock("t3", c_EXP_T3);

        // Same block with 3-cycle holds in MMISS and ENDRN.
        loadRows(c_T3_R0, c_T3_R1, c_T3_R2, c_T3_R1);
        waitDone(1, 13, lat);
        checkVal("t4_latency", 64'(lat), 64'd19);
        finishBlock("t4", c_EXP_T3);

        // Consumer stall in DONE with a beat already waiting.
        loadRows(c_ROW_W, c_ROW_W, c_ROW_K, c_ROW_K);
        waitDone(0, 0, lat);
        inRow   = c_ROW_F;
        inValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
        end
        checkVal("t5_cellStable", outCell, c_EXP_T1);
        checkVal("t5_inReadyLow", 64'(inReady), 64'h0);
        checkVal("t5_outValidHeld", 64'(outValid), 64'h1);
        outReady = 1'b1;
        @(posedge clock); #1;
        outReady = 1'b0;
        checkVal("t5_inReadyAfter", 64'(inReady), 64'h1);
        checkVal("t5_outValidAfter", 64'(outValid), 64'h0);
        @(posedge clock); #1;
        inValid = 1'b0;
        checkVal("t5_beatTaken", 64'(busy), 64'h1);
        sendRow(c_ROW_F);
        sendRow(c_ROW_F);
        sendRow(c_ROW_F);
        waitDone(0, 0, lat);
        checkVal("t5_nextLatency", 64'(lat), 64'd13);
        finishBlock("t5next", c_EXP_T2);

        // Reset during ENISS, then a fresh block.
        loadRows(c_ROW_W, c_ROW_W, c_ROW_K, c_ROW_K);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
        end
        checkVal("t6_inENISS", 64'(ccUIxt), 64'(c_ENC));
        checkVal("t6_ccRp", 64'(ccRp), 64'h0);
        #2;
        reset = 1'b0;
        #1;
        checkVal("t6_rstBusy", 64'(busy), 64'h0);
        checkVal("t6_rstCell", outCell, 64'h0);
        checkVal("t6_rstUIxt", 64'(ccUIxt), 64'h0);
        checkVal("t6_rstInReady", 64'(inReady), 64'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        loadRows(c_T3_R0, c_T3_R1, c_T3_R2, c_T3_R1);
        waitDone(0, 0, lat);
        checkVal("t6_latency", 64'(lat), 64'd13);
        finishBlock("t6", c_EXP_T3);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
